// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matmul result path.
package matmul_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } rtw_state_t;

    // Bits needed to hold a count in 0..n-1. Never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/result_tile_writer.sv
// Result tile writer: streams PE results into result RAM addresses 0..TILE_DEPTH-1,
// toggles a tile-done trigger after the last write of each tile, then blocks input
// for a hold window so the readout sweep can drain the RAM.
module result_tile_writer
    import matmul_pkg::*;
#(
    parameter int D_WIDTH     = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int TILE_DEPTH  = 16,
    parameter int HOLD_CYCLES = TILE_DEPTH + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  res_valid_in,
    input  logic [D_WIDTH-1:0]    res_data_in,
    output logic                  res_ready_out,
    output logic                  res_wr_en_out,
    output logic [ADDR_WIDTH-1:0] res_wr_addr_out,
    output logic [D_WIDTH-1:0]    res_wr_data_out,
    output logic                  output_trigger_out,
    output logic                  busy_out,
    output logic [15:0]           tile_count_out
);

    localparam int PTR_W = cnt_width(TILE_DEPTH);
    localparam int HC_W  = cnt_width(HOLD_CYCLES);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(TILE_DEPTH - 1);
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

    rtw_state_t            state_q, state_d;
    logic                  ready_q, ready_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [HC_W-1:0]       hold_cnt_q, hold_cnt_d;
    // Set by the last-word transfer; the toggle happens one edge later so the
    // trigger edge always follows the final RAM write strobe.
    logic                  tile_done_q, tile_done_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [D_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                  trig_q, trig_d;
    logic [15:0]           tile_cnt_q, tile_cnt_d;
    logic                  xfer;

    // Ready is registered, so a transfer depends only on the stored ready bit.
    assign xfer = res_valid_in && ready_q;

    // Next-state and next-output logic for the FILL/HOLD sequencer.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        tile_done_d = tile_done_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        trig_d      = trig_q;
        tile_cnt_d  = tile_cnt_q;

        case (state_q)
            FILL: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_WIDTH'(wr_ptr_q);
                    wr_data_d = res_data_in;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d    = '0;
                        state_d     = HOLD;
                        tile_done_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tile_done_q) begin
                    trig_d      = ~trig_q;
                    tile_cnt_d  = tile_cnt_q + 16'd1;
                    hold_cnt_d  = HOLD_LOAD;
                    tile_done_d = 1'b0;
                end else if (hold_cnt_q == '0) begin
                    state_d = FILL;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = FILL;
        endcase

        ready_d = (state_d == FILL);
    end

    // State and output registers; reset discards any partial tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            ready_q     <= 1'b0;
            wr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            tile_done_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            trig_q      <= 1'b0;
            tile_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            wr_ptr_q    <= wr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            tile_done_q <= tile_done_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            trig_q      <= trig_d;
            tile_cnt_q  <= tile_cnt_d;
        end
    end

    assign res_ready_out      = ready_q;
    assign res_wr_en_out      = wr_en_q;
    assign res_wr_addr_out    = wr_addr_q;
    assign res_wr_data_out    = wr_data_q;
    assign output_trigger_out = trig_q;
    assign busy_out           = (state_q == HOLD);
    assign tile_count_out     = tile_cnt_q;

endmodule

// File: tb/tb_result_tile_writer.sv
// Directed bench: one writer with TILE_DEPTH=4/HOLD_CYCLES=6, one with 1/1.
module tb_result_tile_writer;

    logic        clk;
    logic        rst_n;

    logic        v0;
    logic [63:0] d0;
    logic        rdy0, we0, trig0, busy0;
    logic [31:0] addr0;
    logic [63:0] wd0;
    logic [15:0] cnt0;

    logic        v1;
    logic [63:0] d1;
    logic        rdy1, we1, trig1, busy1;
    logic [31:0] addr1;
    logic [63:0] wd1;
    logic [15:0] cnt1;

    int checks = 0;
    int errors = 0;

    result_tile_writer #(.D_WIDTH(64), .ADDR_WIDTH(32), .TILE_DEPTH(4), .HOLD_CYCLES(6)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .res_valid_in(v0), .res_data_in(d0), .res_ready_out(rdy0),
        .res_wr_en_out(we0), .res_wr_addr_out(addr0), .res_wr_data_out(wd0),
        .output_trigger_out(trig0), .busy_out(busy0), .tile_count_out(cnt0)
    );

    result_tile_writer #(.D_WIDTH(64), .ADDR_WIDTH(32), .TILE_DEPTH(1), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .res_valid_in(v1), .res_data_in(d1), .res_ready_out(rdy1),
        .res_wr_en_out(we1), .res_wr_addr_out(addr1), .res_wr_data_out(wd1),
        .output_trigger_out(trig1), .busy_out(busy1), .tile_count_out(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready0(input string tag);
        int g = 0;
        while (!rdy0 && g < 30) begin
            tick();
            g++;
        end
        check(tag, rdy0, 1'b1);
    endtask

    // One word with valid high for one cycle, then two idle cycles.
    task automatic send_sparse(input logic [63:0] w, input logic [31:0] a, input string tag);
        v0 = 1'b1;
        d0 = w;
        tick();
        check({tag, "_we"}, we0, 1'b1);
        check({tag, "_addr"}, addr0, a);
        check({tag, "_data"}, wd0, w);
        v0 = 1'b0;
        tick();
        check({tag, "_idle_we"}, we0, 1'b0);
        tick();
    endtask

    logic [63:0] tbl1 [3];

    initial begin
        int lowcnt, g, nwr, ntog, cyc, last_tog;
        logic wr_seen, prev;

        tbl1[0] = 64'h0000_0000_0000_0A01;
        tbl1[1] = 64'h0000_0000_0000_0B02;
        tbl1[2] = 64'h0000_0000_0000_0C03;

        // Reset with valid held high
        rst_n = 1'b0;
        v0 = 1'b1;
        d0 = 64'hAAAA_0000_0000_0001;
        v1 = 1'b0;
        d1 = '0;
        repeat (3) tick();
        check("rst_ready", rdy0, 1'b0);
        check("rst_we", we0, 1'b0);
        check("rst_addr", addr0, 32'd0);
        check("rst_data", wd0, 64'd0);
        check("rst_trig", trig0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_cnt", cnt0, 16'd0);

        rst_n = 1'b1;
        tick();
        check("rel_ready", rdy0, 1'b1);
        check("rel_we", we0, 1'b0);
        check("rel_trig", trig0, 1'b0);

        // Tile 1: A..D back to back
        tick();
        check("t1_we0", we0, 1'b1);
        check("t1_addr0", addr0, 32'd0);
        check("t1_data0", wd0, 64'hAAAA_0000_0000_0001);
        d0 = 64'hBBBB_0000_0000_0002;
        tick();
        check("t1_addr1", addr0, 32'd1);
        check("t1_data1", wd0, 64'hBBBB_0000_0000_0002);
        d0 = 64'hCCCC_0000_0000_0003;
        tick();
        check("t1_addr2", addr0, 32'd2);
        check("t1_data2", wd0, 64'hCCCC_0000_0000_0003);
        d0 = 64'hDDDD_0000_0000_0004;
        tick();
        check("t1_we3", we0, 1'b1);
        check("t1_addr3", addr0, 32'd3);
        check("t1_data3", wd0, 64'hDDDD_0000_0000_0004);
        check("t1_ready_drop", rdy0, 1'b0);
        check("t1_busy", busy0, 1'b1);
        check("t1_trig_before", trig0, 1'b0);

        // Toggle edge, then hold window with valid kept high
        d0 = 64'hEEEE_0000_0000_0005;
        lowcnt = 1;
        wr_seen = 1'b0;
        tick();
        check("t1_trig", trig0, 1'b1);
        check("t1_cnt", cnt0, 16'd1);
        check("t1_we_off", we0, 1'b0);
        if (!rdy0) lowcnt++;
        g = 0;
        while (!rdy0 && g < 20) begin
            tick();
            g++;
            if (we0) wr_seen = 1'b1;
            if (!rdy0) lowcnt++;
        end
        check("hold_low_cycles", lowcnt, 7);
        check("hold_no_wr", wr_seen, 1'b0);
        check("hold_ready_back", rdy0, 1'b1);

        // Tile 2: E..H
        tick();
        check("t2_addr0", addr0, 32'd0);
        check("t2_data0", wd0, 64'hEEEE_0000_0000_0005);
        d0 = 64'hFFFF_0000_0000_0006;
        tick();
        check("t2_addr1", addr0, 32'd1);
        d0 = 64'h1111_0000_0000_0007;
        tick();
        check("t2_addr2", addr0, 32'd2);
        d0 = 64'h2222_0000_0000_0008;
        tick();
        check("t2_addr3", addr0, 32'd3);
        check("t2_data3", wd0, 64'h2222_0000_0000_0008);
        check("t2_trig_before", trig0, 1'b1);
        v0 = 1'b0;
        tick();
        check("t2_trig", trig0, 1'b0);
        check("t2_cnt", cnt0, 16'd2);
        wait_ready0("t2_wait_ready");

        // Sparse valid: one on, two off
        send_sparse(64'h5000_0000_0000_0001, 32'd0, "sp0");
        send_sparse(64'h5000_0000_0000_0002, 32'd1, "sp1");
        send_sparse(64'h5000_0000_0000_0003, 32'd2, "sp2");
        check("sp_trig_mid", trig0, 1'b0);
        check("sp_cnt_mid", cnt0, 16'd2);
        send_sparse(64'h5000_0000_0000_0004, 32'd3, "sp3");
        check("sp_trig", trig0, 1'b1);
        check("sp_cnt", cnt0, 16'd3);
        wait_ready0("sp_wait_ready");

        // Reset after two words of a tile
        v0 = 1'b1;
        d0 = 64'h7000_0000_0000_0001;
        tick();
        check("mr_addr0", addr0, 32'd0);
        d0 = 64'h7000_0000_0000_0002;
        tick();
        check("mr_addr1", addr0, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_we", we0, 1'b0);
        check("mr_addr", addr0, 32'd0);
        check("mr_data", wd0, 64'd0);
        check("mr_trig", trig0, 1'b0);
        check("mr_cnt", cnt0, 16'd0);
        check("mr_ready", rdy0, 1'b0);
        d0 = 64'h7000_0000_0000_0003;
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_ready_back", rdy0, 1'b1);
        tick();
        check("mr_next_we", we0, 1'b1);
        check("mr_next_addr", addr0, 32'd0);
        check("mr_next_data", wd0, 64'h7000_0000_0000_0003);
        v0 = 1'b0;
        repeat (3) tick();
        check("mr_no_toggle", trig0, 1'b0);

        // TILE_DEPTH=1, HOLD_CYCLES=1: three words, continuous valid
        nwr = 0;
        ntog = 0;
        cyc = 0;
        last_tog = 0;
        prev = trig1;
        check("d1_start_trig", trig1, 1'b0);
        v1 = 1'b1;
        d1 = tbl1[0];
        while (ntog < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (we1) begin
                check("d1_addr", addr1, 32'd0);
                check("d1_data", wd1, tbl1[nwr]);
                nwr++;
                if (nwr < 3) d1 = tbl1[nwr];
                else v1 = 1'b0;
            end
            if (trig1 !== prev) begin
                if (ntog > 0) check("d1_spacing", cyc - last_tog, 3);
                last_tog = cyc;
                ntog++;
                prev = trig1;
            end
        end
        check("d1_toggles", ntog, 3);
        check("d1_writes", nwr, 3);
        check("d1_cnt", cnt1, 16'd3);
        check("d1_trig", trig1, 1'b1);
        repeat (3) tick();
        check("d1_quiet_we", we1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
